// File: rtl/uart_tx_framer.sv
// UART transmit frame generator: start, DATA_WIDTH data bits (LSB first), optional parity, 1/2 stop bits.
// Optional line-break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_framer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6,
    parameter int BREAK_BITS = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  BREAK_REQ,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int CNT_MAX = (BREAK_BITS > DATA_WIDTH) ? BREAK_BITS : DATA_WIDTH;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);

`ifdef UART_TX_BREAK_EN
    localparam logic [CW-1:0] LAST_BREAK = CW'(BREAK_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`endif

    // Even parity is the XOR of the word; odd parity inverts it.
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    state_t                  state_r;
    state_t                  state_n;
    logic [CW-1:0]           bit_cnt_r;
    logic [CW-1:0]           bit_cnt_n;
    logic [PRESCALE_W-1:0]   presc_cnt_r;
    logic [PRESCALE_W-1:0]   presc_cnt_n;
    logic [PRESCALE_W-1:0]   presc_r;
    logic [PRESCALE_W-1:0]   presc_eff_s;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [DATA_WIDTH-1:0]   data_shift_s;
    logic                    par_en_r;
    logic                    par_typ_r;
    logic                    stop2_r;
    logic                    tx_out_r;
    logic                    tx_out_n;
    logic                    busy_r;
    logic                    busy_n;
    logic                    load_frame_s;
    logic                    load_break_s;
    logic                    bit_done_s;
    logic                    last_stop_s;

`ifndef UART_TX_BREAK_EN
    logic                    unused_break_req_s;
    assign unused_break_req_s = BREAK_REQ;
`endif

    assign TX_OUT = tx_out_r;
    assign BUSY   = busy_r;

    // Effective bit period, counter terminal detection and stop-bit count decoding.
    always_comb begin
        presc_eff_s = PRESCALE;
        if (PRESCALE == {PRESCALE_W{1'b0}}) begin
            presc_eff_s = PRESCALE_W'(1);
        end else begin
            presc_eff_s = PRESCALE;
        end
        bit_done_s  = (presc_cnt_r == (presc_r - PRESCALE_W'(1)));
        last_stop_s = (bit_cnt_r == {{(CW-1){1'b0}}, stop2_r});
    end

    // Next-state logic: bit sequencing and prescale/bit counter updates.
    always_comb begin
        state_n      = state_r;
        bit_cnt_n    = bit_cnt_r;
        presc_cnt_n  = presc_cnt_r;
        load_frame_s = 1'b0;
        load_break_s = 1'b0;

        if (state_r == ST_IDLE) begin
            presc_cnt_n = {PRESCALE_W{1'b0}};
        end else if (bit_done_s) begin
            presc_cnt_n = {PRESCALE_W{1'b0}};
        end else begin
            presc_cnt_n = presc_cnt_r + PRESCALE_W'(1);
        end

        case (state_r)
            ST_IDLE: begin
                bit_cnt_n = {CW{1'b0}};
`ifdef UART_TX_BREAK_EN
                if (BREAK_REQ) begin
                    load_break_s = 1'b1;
                    state_n      = ST_BREAK;
                end else if (DATA_VALID) begin
                    load_frame_s = 1'b1;
                    state_n      = ST_START;
                end else begin
                    state_n      = ST_IDLE;
                end
`else
                if (DATA_VALID) begin
                    load_frame_s = 1'b1;
                    state_n      = ST_START;
                end else begin
                    state_n      = ST_IDLE;
                end
`endif
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_n   = ST_DATA;
                    bit_cnt_n = {CW{1'b0}};
                end else begin
                    state_n   = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s && (bit_cnt_r == LAST_DATA)) begin
                    bit_cnt_n = {CW{1'b0}};
                    if (par_en_r) begin
                        state_n = ST_PARITY;
                    end else begin
                        state_n = ST_STOP;
                    end
                end else if (bit_done_s) begin
                    bit_cnt_n = bit_cnt_r + CW'(1);
                end else begin
                    bit_cnt_n = bit_cnt_r;
                end
            end
            ST_PARITY: begin
                if (bit_done_s) begin
                    state_n   = ST_STOP;
                    bit_cnt_n = {CW{1'b0}};
                end else begin
                    state_n   = ST_PARITY;
                end
            end
            // bit_cnt_r counts stop bits so a second one reuses the same period logic.
            ST_STOP: begin
                if (bit_done_s && last_stop_s) begin
                    state_n   = ST_IDLE;
                    bit_cnt_n = {CW{1'b0}};
                end else if (bit_done_s) begin
                    bit_cnt_n = bit_cnt_r + CW'(1);
                end else begin
                    bit_cnt_n = bit_cnt_r;
                end
            end
`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
                if (bit_done_s && (bit_cnt_r == LAST_BREAK)) begin
                    state_n   = ST_IDLE;
                    bit_cnt_n = {CW{1'b0}};
                end else if (bit_done_s) begin
                    bit_cnt_n = bit_cnt_r + CW'(1);
                end else begin
                    bit_cnt_n = bit_cnt_r;
                end
            end
`endif
            default: begin
                state_n     = ST_IDLE;
                bit_cnt_n   = {CW{1'b0}};
                presc_cnt_n = {PRESCALE_W{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so TX_OUT/BUSY change on the same edge as the state.
    always_comb begin
        tx_out_n     = 1'b1;
        data_shift_s = data_r >> bit_cnt_n;
        case (state_n)
            ST_IDLE:   tx_out_n = 1'b1;
            ST_START:  tx_out_n = 1'b0;
            ST_DATA:   tx_out_n = data_shift_s[0];
            ST_PARITY: tx_out_n = parity_bit(data_r, par_typ_r);
            ST_STOP:   tx_out_n = 1'b1;
`ifdef UART_TX_BREAK_EN
            ST_BREAK:  tx_out_n = 1'b0;
`endif
            default:   tx_out_n = 1'b1;
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    // State and counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= {CW{1'b0}};
            presc_cnt_r <= {PRESCALE_W{1'b0}};
        end else begin
            state_r     <= state_n;
            bit_cnt_r   <= bit_cnt_n;
            presc_cnt_r <= presc_cnt_n;
        end
    end

    // Frame configuration captured at acceptance and frozen until the frame ends.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_r    <= {DATA_WIDTH{1'b0}};
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
            stop2_r   <= 1'b0;
            presc_r   <= PRESCALE_W'(1);
        end else if (load_frame_s) begin
            data_r    <= P_DATA;
            par_en_r  <= PAR_EN;
            par_typ_r <= PAR_TYP;
            stop2_r   <= STOP2;
            presc_r   <= presc_eff_s;
        end else if (load_break_s) begin
            presc_r   <= presc_eff_s;
        end
    end

    // Registered serial line and busy flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_out_r <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            tx_out_r <= tx_out_n;
            busy_r   <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: a driver queues the expected line waveform per frame,
// a monitor compares every clock of each frame seen on TX_OUT/BUSY against it.
module tb_uart_tx_framer;

    localparam int DW = 8;
    localparam int PW = 6;
    localparam int BB = 16;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          STOP2;
    logic [PW-1:0] PRESCALE;
    logic          BREAK_REQ;
    logic          TX_OUT;
    logic          BUSY;

    uart_tx_framer #(.DATA_WIDTH(DW), .PRESCALE_W(PW), .BREAK_BITS(BB)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .PRESCALE(PRESCALE),
        .BREAK_REQ(BREAK_REQ), .TX_OUT(TX_OUT), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One expected line event: a list of bit values, each held p clocks.
    typedef struct {
        logic [31:0] bits;
        int          nbits;
        int          p;
        logic [7:0]  d;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    function automatic exp_t make_frame(input logic [7:0] d, input bit pe, input bit pt,
                                        input bit s2, input int p);
        exp_t e;
        int   n;
        e.bits = 32'hFFFF_FFFF;
        e.d    = d;
        e.p    = (p == 0) ? 1 : p;
        n = 0;
        e.bits[n] = 1'b0; n++;
        for (int i = 0; i < DW; i++) begin
            e.bits[n] = d[i]; n++;
        end
        if (pe) begin
            e.bits[n] = (($countones(d) % 2) == 1) ? ~pt : pt; n++;
        end
        e.bits[n] = 1'b1; n++;
        if (s2) begin
            e.bits[n] = 1'b1; n++;
        end
        e.nbits = n;
        return e;
    endfunction

    function automatic exp_t make_break(input int p);
        exp_t e;
        e.bits  = 32'h0;
        e.nbits = BB;
        e.p     = (p == 0) ? 1 : p;
        e.d     = 8'h00;
        return e;
    endfunction

    task automatic check_bit(input string name, input logic got, input logic exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor state
    bit   mon_in_frame = 1'b0;
    bit   mon_prev_busy = 1'b0;
    bit   mon_ok = 1'b1;
    int   mon_c = 0;
    int   mon_bad_c = 0;
    logic mon_bad_tx = 1'b0;
    logic mon_bad_busy = 1'b0;
    logic mon_exp_tx = 1'b0;
    exp_t mon_cur;

    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                mon_in_frame  = 1'b0;
                mon_prev_busy = 1'b0;
            end else begin
                if (!mon_in_frame && BUSY && !mon_prev_busy) begin
                    if (sb.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL unexpected_frame: BUSY rose with nothing expected at %0t", $time);
                    end else begin
                        mon_cur      = sb.pop_front();
                        mon_in_frame = 1'b1;
                        mon_c        = 0;
                        mon_ok       = 1'b1;
                    end
                end
                if (mon_in_frame) begin
                    if (mon_c < mon_cur.nbits * mon_cur.p) begin
                        mon_exp_tx = mon_cur.bits[mon_c / mon_cur.p];
                        if (mon_ok && (BUSY !== 1'b1 || TX_OUT !== mon_exp_tx)) begin
                            mon_ok       = 1'b0;
                            mon_bad_c    = mon_c;
                            mon_bad_tx   = TX_OUT;
                            mon_bad_busy = BUSY;
                        end
                        mon_c++;
                    end else begin
                        tests_run++;
                        if (!mon_ok) begin
                            tests_failed++;
                            $display("FAIL frame d=%h p=%0d: clk %0d tx=%b busy=%b expected tx=%b busy=1",
                                     mon_cur.d, mon_cur.p, mon_bad_c, mon_bad_tx, mon_bad_busy,
                                     mon_cur.bits[mon_bad_c / mon_cur.p]);
                        end else if (BUSY !== 1'b0 || TX_OUT !== 1'b1) begin
                            tests_failed++;
                            $display("FAIL frame_end d=%h p=%0d: after %0d clks tx=%b busy=%b expected tx=1 busy=0",
                                     mon_cur.d, mon_cur.p, mon_c, TX_OUT, BUSY);
                        end
                        mon_in_frame = 1'b0;
                    end
                end
                mon_prev_busy = BUSY;
            end
        end
    end

    task automatic scramble();
        P_DATA   = DW'($urandom);
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
        STOP2    = 1'($urandom);
        PRESCALE = PW'($urandom);
`ifdef UART_TX_BREAK_EN
        BREAK_REQ = 1'b0;
`else
        BREAK_REQ = 1'($urandom);
`endif
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge CLK);
        while (BUSY === 1'b1 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 300) begin
            tests_run++;
            tests_failed++;
            $display("FAIL idle_timeout: BUSY still %b after %0d clks", BUSY, n);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pe, input bit pt,
                              input bit s2, input logic [PW-1:0] p);
        wait_idle();
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        STOP2      = s2;
        PRESCALE   = p;
        DATA_VALID = 1'b1;
        sb.push_back(make_frame(d, pe, pt, s2, int'(p)));
        @(posedge CLK);
        #1;
        DATA_VALID = 1'b0;
        scramble();
    endtask

    initial begin
        int n;
        RST        = 1'b1;
        P_DATA     = '0;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        STOP2      = 1'b0;
        PRESCALE   = PW'(1);
        BREAK_REQ  = 1'b0;
        repeat (3) @(negedge CLK);
        check_bit("reset_tx", TX_OUT, 1'b1);
        check_bit("reset_busy", BUSY, 1'b0);
        RST = 1'b0;

        // Directed frames from the plan.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, PW'(1));
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, PW'(4));
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, PW'(2));
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, PW'(0));

        // Back-to-back with DATA_VALID held high; data changes during frame 1.
        wait_idle();
        P_DATA = 8'h11; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; PRESCALE = PW'(1);
        BREAK_REQ  = 1'b0;
        DATA_VALID = 1'b1;
        sb.push_back(make_frame(8'h11, 1'b0, 1'b0, 1'b0, 1));
        @(posedge CLK);
        #1;
        P_DATA = 8'h22;
        sb.push_back(make_frame(8'h22, 1'b0, 1'b0, 1'b0, 1));
        n = 0;
        @(negedge CLK);
        while (BUSY === 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check_bit("b2b_idle_clock", BUSY, 1'b0);
        @(negedge CLK);
        check_bit("b2b_restart", BUSY, 1'b1);
        DATA_VALID = 1'b0;

        // Reset in the middle of the 5th data bit, P=3.
        send_frame(8'hC9, 1'b1, 1'b0, 1'b1, PW'(3));
        repeat (16) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check_bit("midreset_tx", TX_OUT, 1'b1);
        check_bit("midreset_busy", BUSY, 1'b0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        check_bit("post_reset_idle", BUSY, 1'b0);
        send_frame(8'h96, 1'b1, 1'b1, 1'b0, PW'(3));

`ifdef UART_TX_BREAK_EN
        // Break has priority over a simultaneous data request.
        wait_idle();
        P_DATA = 8'h5A; PAR_EN = 1'b0; STOP2 = 1'b0; PRESCALE = PW'(2);
        BREAK_REQ  = 1'b1;
        DATA_VALID = 1'b1;
        sb.push_back(make_break(2));
        @(posedge CLK);
        #1;
        BREAK_REQ  = 1'b0;
        DATA_VALID = 1'b0;
`endif

        // Randomised frames.
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       PW'($urandom_range(0, 5)));
        end

        n = 0;
        while ((sb.size() != 0 || mon_in_frame || BUSY === 1'b1) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        repeat (4) @(negedge CLK);
        tests_run++;
        if (sb.size() != 0 || mon_in_frame) begin
            tests_failed++;
            $display("FAIL drain: %0d frames still expected, in_frame=%b", sb.size(), mon_in_frame);
        end
        check_bit("final_idle_tx", TX_OUT, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
